nibble_serial_adder_ctrl: RTL and testbench

Sequencer that time-shares one 4-bit ripple-carry adder core to add two N-nibble operands, one nibble per clock, starting with the least significant nibble. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It is the control layer above the existing 4-bit parallel adder datapath and lets that single adder serve wide additions without replicating it.

---
 rtl/nsa_pkg.sv | 23 ++
 rtl/nibble_adder_core.sv | 27 ++
 rtl/nibble_serial_adder_ctrl.sv | 103 ++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: controller states,
// nibble width and the index-width helper.
package nsa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest w with 2**w >= n; a loop with a constant bound stays synthesizable.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/nibble_adder_core.sv
// Combinational 4-bit ripple-carry adder; exports the carry into bit 3
// so the controller can derive signed overflow of the top nibble.
module nibble_adder_core
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co,
  output logic                c3
);

  logic [NIBBLE_W:0] c;

  // NOTE: blocking assignments here so each stage sees the carry computed just above it.
  always_comb begin
    c[0] = ci;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[NIBBLE_W];
    c3 = c[NIBBLE_W-1];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequencer that runs one 4-bit adder core over NIBBLES nibbles, LSB first,
// with valid/ready handshakes on the operand and result sides.
module nibble_serial_adder_ctrl
  import nsa_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        cin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                        cout,
  output logic                        ovf,
  output logic                        busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t           state, state_next;
  logic [W-1:0]     a_reg, b_reg, sum_reg;
  logic [IDX_W-1:0] idx;
  logic             carry_reg, cout_reg, ovf_reg;

  logic [NIBBLE_W-1:0] core_s;
  logic                core_co, core_c3;

  nibble_adder_core u_core (
    .a  (a_reg[idx*NIBBLE_W +: NIBBLE_W]),
    .b  (b_reg[idx*NIBBLE_W +: NIBBLE_W]),
    .ci (carry_reg),
    .s  (core_s),
    .co (core_co),
    .c3 (core_c3)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)        state_next = ADD;
      ADD:     if (idx == LAST_IDX) state_next = DONE;
      DONE:    if (out_ready)       state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // NOTE: operand and result registers are reset too, so an aborted operation leaves no residue.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      idx       <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            sum_reg   <= '0;
            idx       <= '0;
          end
        end
        ADD: begin
          sum_reg[idx*NIBBLE_W +: NIBBLE_W] <= core_s;
          carry_reg                         <= core_co;
          idx                               <= idx + 1'b1;
          // Flags are taken from the top nibble only.
          if (idx == LAST_IDX) begin
            cout_reg <= core_co;
            ovf_reg  <= core_c3 ^ core_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench: directed, random, backpressure, abort and exhaustive
// single-nibble checks against an arithmetic reference model.
module tb_nibble_serial_adder_ctrl;

  localparam int N4 = 4;
  localparam int W4 = 16;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Four-nibble instance
  logic          in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, busy;
  logic [W4-1:0] a, b, sum;

  // Single-nibble instance
  logic       in_valid_1, in_ready_1, cin_1, out_valid_1, out_ready_1, cout_1, ovf_1, busy_1;
  logic [3:0] a_1, b_1, sum_1;

  nibble_serial_adder_ctrl #(.NIBBLES(N4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  nibble_serial_adder_ctrl #(.NIBBLES(1)) dut_1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .a(a_1), .b(b_1), .cin(cin_1), .out_valid(out_valid_1), .out_ready(out_ready_1),
    .sum(sum_1), .cout(cout_1), .ovf(ovf_1), .busy(busy_1)
  );

  typedef struct {
    logic [W4-1:0] s;
    logic          co;
    logic          ov;
  } exp_t;

  // Reference: plain wide addition; overflow when both operands share a sign the sum lacks.
  function automatic exp_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                 input logic ci);
    exp_t        e;
    logic [63:0] mask, full, s;
    mask = (64'd1 << w) - 64'd1;
    full = (av & mask) + (bv & mask) + {63'd0, ci};
    s    = full & mask;
    e.s  = W4'(s);
    e.co = full[w];
    e.ov = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
    return e;
  endfunction

  // Starts just after a negedge with the 4-nibble DUT idle; returns cycles from accept to out_valid.
  task automatic drive_op4(input logic [W4-1:0] av, input logic [W4-1:0] bv, input logic ci,
                           input logic rdy_in_add, output int lat);
    in_valid = 1'b1; a = av; b = bv; cin = ci;
    @(posedge clk); @(negedge clk);
    in_valid  = 1'b0;
    a         = W4'($urandom);
    b         = W4'($urandom);
    cin       = 1'($urandom);
    out_ready = rdy_in_add;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic consume4();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    in_valid_1 = 1'b0; a_1 = '0; b_1 = '0; cin_1 = 1'b0; out_ready_1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({in_ready, out_valid, busy, sum, cout, ovf} !== {3'b100, 16'h0, 2'b00}) begin
      fails++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b ovf=%b, required 1 0 0 0000 0 0",
               in_ready, out_valid, busy, sum, cout, ovf);
    end
    tests++;
    if ({in_ready_1, out_valid_1, busy_1, sum_1, cout_1, ovf_1} !== {3'b100, 4'h0, 2'b00}) begin
      fails++;
      $display("FAIL reset_1: in_ready=%b out_valid=%b busy=%b sum=%h, required 1 0 0 0",
               in_ready_1, out_valid_1, busy_1, sum_1);
    end
  endtask

  task automatic test_directed();
    logic [W4-1:0] va[5] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000};
    logic [W4-1:0] vb[5] = '{16'h0FFF, 16'h0001, 16'h0000, 16'h0001, 16'h8000};
    logic          vc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_t e;
    int   lat;
    for (int i = 0; i < 5; i++) begin
      e = model(W4, 64'(va[i]), 64'(vb[i]), vc[i]);
      drive_op4(va[i], vb[i], vc[i], 1'b0, lat);
      tests++;
      if ({sum, cout, ovf} !== {e.s, e.co, e.ov} || lat != N4 || busy !== 1'b1) begin
        fails++;
        $display("FAIL directed_%0d: sum=%h cout=%b ovf=%b lat=%0d busy=%b, required sum=%h cout=%b ovf=%b lat=%0d busy=1",
                 i, sum, cout, ovf, lat, busy, e.s, e.co, e.ov, N4);
      end
      consume4();
    end
  endtask

  task automatic test_random();
    logic [W4-1:0] av, bv;
    logic          ci;
    exp_t          e;
    int            lat;
    for (int i = 0; i < 40; i++) begin
      av = W4'($urandom); bv = W4'($urandom); ci = 1'($urandom);
      e  = model(W4, 64'(av), 64'(bv), ci);
      drive_op4(av, bv, ci, 1'($urandom), lat);
      tests++;
      if ({sum, cout, ovf} !== {e.s, e.co, e.ov} || lat != N4) begin
        fails++;
        $display("FAIL random_%0d: %h+%h+%b sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=%0d",
                 i, av, bv, ci, sum, cout, ovf, lat, e.s, e.co, e.ov, N4);
      end
      consume4();
    end
  endtask

  task automatic test_backpressure();
    exp_t e, e2;
    int   lat;
    e  = model(W4, 64'h1234, 64'h0FFF, 1'b0);
    e2 = model(W4, 64'h0001, 64'h0001, 1'b0);
    drive_op4(16'h1234, 16'h0FFF, 1'b0, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = W4'($urandom); b = W4'($urandom);
      @(posedge clk); @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || sum !== e.s || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL backpressure_hold_%0d: out_valid=%b sum=%h in_ready=%b, required 1 %h 0",
                 i, out_valid, sum, in_ready, e.s);
      end
    end
    out_ready = 1'b1; in_valid = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    drive_op4(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
    tests++;
    if (sum !== e2.s || lat != N4) begin
      fails++;
      $display("FAIL backpressure_next: sum=%h lat=%0d, required %h %0d", sum, lat, e2.s, N4);
    end
    consume4();
  endtask

  task automatic test_back_to_back();
    exp_t          q[$];
    exp_t          e;
    logic [W4-1:0] av, bv;
    logic          ci;
    int            n_acc = 0;
    int            last  = -1;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && (n_acc < 3 || q.size() > 0); k++) begin
      if (out_valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL b2b_extra: unexpected out_valid with sum=%h", sum);
        end else begin
          e = q.pop_front();
          if ({sum, cout, ovf} !== {e.s, e.co, e.ov}) begin
            fails++;
            $display("FAIL b2b_result: sum=%h cout=%b ovf=%b, required %h %b %b",
                     sum, cout, ovf, e.s, e.co, e.ov);
          end
        end
      end
      if (in_ready && n_acc < 3) begin
        av = W4'($urandom); bv = W4'($urandom); ci = 1'($urandom);
        in_valid = 1'b1; a = av; b = bv; cin = ci;
        q.push_back(model(W4, 64'(av), 64'(bv), ci));
        if (last >= 0) begin
          tests++;
          if (cyc - last != N4 + 2) begin
            fails++;
            $display("FAIL b2b_interval: got %0d cycles, required %0d", cyc - last, N4 + 2);
          end
        end
        last = cyc;
        n_acc++;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tests++;
    if (n_acc != 3 || q.size() != 0) begin
      fails++;
      $display("FAIL b2b_timeout: accepted=%0d pending=%0d, required 3 0", n_acc, q.size());
    end
  endtask

  task automatic test_abort();
    exp_t e;
    int   lat;
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_busy: busy=%b, required 1", busy);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({in_ready, out_valid, busy, sum, cout, ovf} !== {3'b100, 16'h0, 2'b00}) begin
      fails++;
      $display("FAIL abort_clear: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b ovf=%b, required 1 0 0 0000 0 0",
               in_ready, out_valid, busy, sum, cout, ovf);
    end
    e = model(W4, 64'h0003, 64'h0004, 1'b0);
    drive_op4(16'h0003, 16'h0004, 1'b0, 1'b0, lat);
    tests++;
    if ({sum, cout, ovf} !== {e.s, e.co, e.ov} || lat != N4) begin
      fails++;
      $display("FAIL abort_next: sum=%h cout=%b ovf=%b lat=%0d, required %h %b %b %0d",
               sum, cout, ovf, lat, e.s, e.co, e.ov, N4);
    end
    consume4();
  endtask

  task automatic test_exhaustive_nibble();
    exp_t e;
    int   lat;
    for (int ci = 0; ci < 2; ci++) begin
      for (int av = 0; av < 16; av++) begin
        for (int bv = 0; bv < 16; bv++) begin
          e = model(4, 64'(av), 64'(bv), 1'(ci));
          in_valid_1 = 1'b1; a_1 = 4'(av); b_1 = 4'(bv); cin_1 = 1'(ci);
          @(posedge clk); @(negedge clk);
          in_valid_1 = 1'b0; a_1 = 4'($urandom); b_1 = 4'($urandom);
          lat = -1;
          for (int c = 1; c <= 10; c++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid_1) begin
              lat = c;
              break;
            end
          end
          tests++;
          if ({cout_1, sum_1, ovf_1} !== {e.co, e.s[3:0], e.ov} || lat != 1) begin
            fails++;
            $display("FAIL nibble_%0h_%0h_%0d: cout=%b sum=%h ovf=%b lat=%0d, required %b %h %b 1",
                     av, bv, ci, cout_1, sum_1, ovf_1, lat, e.co, e.s[3:0], e.ov);
          end
          out_ready_1 = 1'b1;
          @(posedge clk); @(negedge clk);
          out_ready_1 = 1'b0;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_exhaustive_nibble();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
